// File: rtl/ntt_ctrl_pkg.sv
// Shared constants and state encoding for the NTT stage controller and its helpers.
package ntt_ctrl_pkg;

    localparam int unsigned NTT_LEN      = 128;
    localparam int unsigned NTT_PIPE_LAT = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stage_state_e;

    // Counter width that still holds n-1, never narrower than one bit.
    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module window_down_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero_c
);

    assign zero_c = (count == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero_c) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/ntt_stage_window.sv
// Turns a start pulse into a busy/index window for one NTT stage, followed by a
// drain window covering the butterfly pipeline and a done pulse in its last cycle.
module ntt_stage_window
    import ntt_ctrl_pkg::*;
#(
    parameter  int unsigned LEN      = NTT_LEN,
    parameter  int unsigned PIPE_LAT = NTT_PIPE_LAT,
    localparam int unsigned CNT_W    = min_width(LEN),
    localparam int unsigned DRN_W    = $clog2(PIPE_LAT + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_pulse,
    input  logic             abort,
    output logic             busy,
    output logic [CNT_W-1:0] idx,
    output logic             first,
    output logic             last,
    output logic             drain,
    output logic             done,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(PIPE_LAT - 1);

    stage_state_e     state, state_d;
    logic [CNT_W-1:0] idx_d;
    logic             busy_d, first_d, last_d, drain_d, done_d, overrun_d;
    logic             start_acc;
    logic             dload, ddec, dzero;
    logic [DRN_W-1:0] dcnt;

    window_down_counter #(.W(DRN_W)) u_drain_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (dload),
        .load_val (DRN_LOAD),
        .dec      (ddec),
        .count    (dcnt),
        .zero_c   (dzero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            first   <= 1'b0;
            last    <= 1'b0;
            drain   <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            busy    <= busy_d;
            first   <= first_d;
            last    <= last_d;
            drain   <= drain_d;
            done    <= done_d;
            overrun <= overrun_d;
        end
    end

    // Next state, then outputs decoded from the next state so they land registered.
    always_comb begin
        state_d   = state;
        idx_d     = '0;
        busy_d    = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        drain_d   = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun;
        dload     = 1'b0;
        ddec      = 1'b0;
        start_acc = start_pulse && ((state == IDLE) || ((state == DRAIN) && dzero));

        if (abort) begin
            state_d = IDLE;
        end else if (start_acc) begin
            state_d   = RUN;
            overrun_d = 1'b0;
        end else begin
            if (start_pulse) begin
                overrun_d = 1'b1;
            end
            case (state)
                RUN: begin
                    if (idx == LAST_IDX) begin
                        state_d = DRAIN;
                        dload   = 1'b1;
                    end
                end
                DRAIN: begin
                    if (dzero) begin
                        state_d = IDLE;
                    end else begin
                        ddec = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        case (state_d)
            RUN: begin
                busy_d  = 1'b1;
                idx_d   = (state == RUN) ? idx + CNT_W'(1) : '0;
                first_d = (idx_d == '0);
                last_d  = (idx_d == LAST_IDX);
            end
            DRAIN: begin
                drain_d = 1'b1;
                done_d  = dload ? (PIPE_LAT == 1) : (dcnt == DRN_W'(1));
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ntt_stage_window.md
Name: ntt_stage_window

Overview:
- Converts a single-cycle start pulse into a timed activity window for one NTT stage. The pulse typically comes from the controller's rising-edge detector.
- Outputs: a busy level, a running butterfly index with first/last flags, a drain level that covers the butterfly pipeline latency, and a one-cycle done pulse.
- Direction is pulse-to-level, the inverse of edge detection. Sits between the top-level controller and the address generator / butterfly pair.

Parameters:
- LEN, 128, butterfly cycles per stage; legal range ≥1.
- PIPE_LAT, 9, butterfly pipeline depth in cycles (matches the 9-stage delay line); legal range ≥1.
- CNT_W, $clog2(LEN) (minimum 1), width of idx.
- DRN_W, $clog2(PIPE_LAT+1), width of the internal drain counter.

Ports:
- clk, in, 1, rising-edge clock.
- rstn, in, 1, asynchronous active-low reset.
- start_pulse, in, 1, request a new stage window; sampled every rising edge.
- abort, in, 1, synchronous cancel; highest priority.
- busy, out, 1, high while butterfly inputs are issued.
- idx, out, CNT_W, butterfly index 0..LEN-1 while busy, else 0.
- first, out, 1, high when busy and idx==0.
- last, out, 1, high when busy and idx==LEN-1.
- drain, out, 1, high while the pipeline flushes after the last issue.
- done, out, 1, one-cycle pulse in the final drain cycle.
- overrun, out, 1, sticky: a start arrived while the window was active.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low. All outputs are registered and reset to 0; FSM resets to IDLE.
- FSM states:
  - IDLE → RUN on accepted start.
  - RUN → DRAIN after the idx==LEN-1 cycle.
  - DRAIN → IDLE after PIPE_LAT cycles, or DRAIN → RUN on a back-to-back start.
  - any state → IDLE on abort.
- Timing, with start_pulse high in cycle c and accepted:
  - Cycle c+1: busy=1, idx=0, first=1.
  - idx increments by 1 per cycle.
  - Cycle c+LEN: idx=LEN-1, last=1. If LEN=1, first and last are high in the same cycle.
  - Cycles c+LEN+1 .. c+LEN+PIPE_LAT: busy=0, idx=0, drain=1.
  - done=1 only in cycle c+LEN+PIPE_LAT.
  - Cycle c+LEN+PIPE_LAT+1: all outputs 0, except overrun.
- Acceptance rule: start_pulse is accepted in IDLE, or in the done cycle (back-to-back).
  - For back-to-back, busy rises in the cycle after done and drain falls in that same cycle. There is no gap cycle.
- Start while active: start_pulse in RUN, or in DRAIN outside the done cycle, is ignored. The window is unaffected and overrun is set to 1 from the next cycle.
- overrun stays set until the cycle after the next accepted start, when it clears together with the rise of busy.
  - A start that is both accepted and would overrun is impossible by construction.
- Abort: abort high in cycle d gives IDLE in d+1.
  - busy, drain, first, last and idx are 0 in d+1. No done pulse is produced. overrun is unchanged.
  - Abort and start in the same cycle: abort wins, start is dropped, overrun is not set.
  - Abort in the done cycle: done is still high in that cycle (already registered). The next state is IDLE even if start is high.
- Reset mid-window: immediate return to IDLE, outputs 0, overrun cleared.
- Width rules:
  - idx never exceeds LEN-1. Wrap is never reached because RUN exits at LEN-1.
  - The drain counter loads PIPE_LAT-1 and counts down to 0. done is asserted while the counter equals 0 in DRAIN.
- start_pulse must be a single-cycle pulse. A held level is treated as a repeated start every cycle, so it sets overrun during the window.

Decomposition:
- Shared package (ntt_ctrl_pkg):
  - FSM state encoding localparams: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
  - Default LEN=128 and PIPE_LAT=9 constants, used by the stage controller and the delay line.
- Sub-module: one is natural, window_down_counter. It is a loadable down-counter with a zero flag, used for the drain counter.
- The idx up-counter stays inline.

Test Plan:
1. LEN=4, PIPE_LAT=3, single start pulse at cycle 10 → busy high in cycles 11–14; idx 0,1,2,3; first in 11; last in 14; drain in 15–17; done only in 17; all outputs 0 in 18.
2. LEN=4, PIPE_LAT=3, starts at cycles 10 and 17 → second window busy from 18 with idx=0 and first=1; drain low in 18; overrun stays 0.
3. LEN=4, PIPE_LAT=3, starts at 10 and 13 → first window unchanged; overrun=1 from cycle 14; next accepted start at 20 → busy=1 and overrun=0 in cycle 21.
4. Defaults (LEN=128, PIPE_LAT=9), start at 0, abort at 50 → cycle 51: busy=0, idx=0; no done ever; start at 60 → busy at 61, done at 60+128+9=197.
5. LEN=1, PIPE_LAT=1, start at 5 → cycle 6 busy=first=last=1, idx=0; cycle 7 drain=done=1; cycle 8 all 0.
6. rstn low asynchronously mid-RUN (defaults, idx=40) → outputs 0 immediately without a clock edge; after release a new start behaves as in scenario 4.
